// File: rtl/mem2d_pkg.sv
// mem2d_pkg: shared definitions for the 64x32x8 two-dimensional byte memory clients.
//   - default address/data widths
//   - reader FSM state enum
//   - FIFO entry carried from the memory read port to the output stream
package mem2d_pkg;

    localparam int unsigned AX_W_DEF   = 6;
    localparam int unsigned AY_W_DEF   = 5;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } rd_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  eol;
        logic                  last;
    } rd_entry_t;

endpackage

// File: rtl/mem2d_rd_skid.sv
// mem2d_rd_skid: 2-entry synchronous fall-through FIFO.
// An entry pushed into an empty FIFO is visible on head in the same cycle, and is
// consumed without being stored if popped in that cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_entry  write strobe and entry (must not push when full)
//   pop             read strobe (only while valid)
//   count           stored entries (0..2), excluding a same-cycle bypass
//   valid           head holds an entry (stored or bypassed)
//   head            oldest entry
module mem2d_rd_skid
    import mem2d_pkg::*;
#(
    parameter type entry_t = rd_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    output logic [1:0] count,
    output logic       valid,
    output entry_t     head
);

    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    logic empty;
    logic bypass;
    logic do_wr;
    logic do_rd;

    always_comb begin
        empty  = (count_q == 2'd0);
        valid  = !empty || push;
        head   = empty ? push_entry : mem_q[rd_ptr_q];
        bypass = empty && push && pop;
        do_wr  = push && !bypass;
        do_rd  = pop && !empty;
        count  = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_wr} - {1'b0, do_rd};
        end
    end

endmodule

// File: rtl/mem2d_raster_reader.sv
// mem2d_raster_reader: scans a rectangular window of the 2-D byte memory and streams
// the elements out on a valid/ready interface with end-of-line and end-of-window marks.
// Build option: MEM2D_RD_COLMAJOR_EN selects a column-major scan (out_eol then marks
// the last element of each column); default is row-major.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, x0, y0, win_w, win_h scan request and window (sizes 1..64 / 1..32)
//   mem_addr_x/y, mem_rd_en     memory read port; mem_data returns one cycle later
//   mem_wr_enable               always 0
//   out_data/valid/ready        output stream
//   out_eol, out_last           row (column) end and window end flags
//   busy, done                  scan active, one-cycle completion pulse
// DATA_W must equal the package entry data width.
module mem2d_raster_reader
    import mem2d_pkg::*;
#(
    parameter int unsigned AX_W   = AX_W_DEF,
    parameter int unsigned AY_W   = AY_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AX_W-1:0]   x0,
    input  logic [AY_W-1:0]   y0,
    input  logic [AX_W:0]     win_w,
    input  logic [AY_W:0]     win_h,
    output logic [AX_W-1:0]   mem_addr_x,
    output logic [AY_W-1:0]   mem_addr_y,
    output logic              mem_rd_en,
    output logic              mem_wr_enable,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [AX_W:0] WinWMax = (AX_W+1)'(1 << AX_W);
    localparam logic [AY_W:0] WinHMax = (AY_W+1)'(1 << AY_W);

    rd_state_e       state_q, state_d;
    logic [AX_W-1:0] x0_q, x0_d;
    logic [AY_W-1:0] y0_q, y0_d;
    logic [AX_W:0]   w_q, w_d;
    logic [AY_W:0]   h_q, h_d;
    logic [AX_W:0]   col_q, col_d;
    logic [AY_W:0]   row_q, row_d;
    logic [AX_W-1:0] addr_x_q;
    logic [AY_W-1:0] addr_y_q;
    logic            inflight_q;
    logic            eol_q;
    logic            last_q;

    logic            col_last;
    logic            row_last;
    logic            issue_eol;
    logic            issue_last;
    logic [AX_W-1:0] cur_x;
    logic [AY_W-1:0] cur_y;
    logic            pop;
    logic [2:0]      occ;
    logic            legal;

    rd_entry_t       push_entry;
    rd_entry_t       head;
    logic [1:0]      fifo_count;
    logic            fifo_valid;

    mem2d_rd_skid #(
        .entry_t (rd_entry_t)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (fifo_count),
        .valid      (fifo_valid),
        .head       (head)
    );

    // Returned data joins the flags computed when its read was issued.
    always_comb begin
        push_entry.data = mem_data;
        push_entry.eol  = eol_q;
        push_entry.last = last_q;
    end

    always_comb begin
        col_last   = (col_q == w_q - (AX_W+1)'(1));
        row_last   = (row_q == h_q - (AY_W+1)'(1));
`ifdef MEM2D_RD_COLMAJOR_EN
        issue_eol  = row_last;
`else
        issue_eol  = col_last;
`endif
        issue_last = col_last && row_last;
        // Truncation makes windows wrap around the memory edges.
        cur_x      = x0_q + col_q[AX_W-1:0];
        cur_y      = y0_q + row_q[AY_W-1:0];
        pop        = fifo_valid && out_ready;
        // Entries that will occupy the FIFO next cycle if nothing new is issued.
        occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        mem_rd_en  = (state_q == StScan) && (occ < 3'd2);
        legal      = (win_w != '0) && (win_w <= WinWMax) &&
                     (win_h != '0) && (win_h <= WinHMax);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && legal) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = win_w;
                    h_d     = win_h;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (mem_rd_en) begin
`ifdef MEM2D_RD_COLMAJOR_EN
                    if (row_last) begin
                        row_d = '0;
                        col_d = col_q + (AX_W+1)'(1);
                    end else begin
                        row_d = row_q + (AY_W+1)'(1);
                    end
`else
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + (AY_W+1)'(1);
                    end else begin
                        col_d = col_q + (AX_W+1)'(1);
                    end
`endif
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_count == 2'd0 && !inflight_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr_x    = mem_rd_en ? cur_x : addr_x_q;
        mem_addr_y    = mem_rd_en ? cur_y : addr_y_q;
        mem_wr_enable = 1'b0;
        out_valid     = fifo_valid;
        out_data      = fifo_valid ? head.data : '0;
        out_eol       = fifo_valid && head.eol;
        out_last      = fifo_valid && head.last;
        busy          = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_x_q   <= '0;
            addr_y_q   <= '0;
            inflight_q <= 1'b0;
            eol_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= mem_rd_en;
            eol_q      <= mem_rd_en && issue_eol;
            last_q     <= mem_rd_en && issue_last;
            if (mem_rd_en) begin
                addr_x_q <= cur_x;
                addr_y_q <= cur_y;
            end
        end
    end

endmodule

// File: tb/tb_mem2d_raster_reader.sv
module tb_mem2d_raster_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] x0 = '0;
    logic [4:0] y0 = '0;
    logic [6:0] win_w = '0;
    logic [5:0] win_h = '0;
    logic [5:0] mem_addr_x;
    logic [4:0] mem_addr_y;
    logic       mem_rd_en;
    logic       mem_wr_enable;
    logic [7:0] mem_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_eol;
    logic       out_last;
    logic       busy;
    logic       done;

    mem2d_raster_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .x0            (x0),
        .y0            (y0),
        .win_w         (win_w),
        .win_h         (win_h),
        .mem_addr_x    (mem_addr_x),
        .mem_addr_y    (mem_addr_y),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_enable (mem_wr_enable),
        .mem_data      (mem_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_eol       (out_eol),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory preload: mem[x][y] = x + 8*y (mod 256).
    function automatic logic [7:0] mem_val(input int x, input int y);
        logic [7:0] v;
        v = 8'(x + 8 * y);
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem_val(int'(mem_addr_x), int'(mem_addr_y));
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Log of reads, beats and done pulses, sampled on the falling edge.
    int rd_x[$], rd_y[$], rd_cyc[$];
    int bt_d[$], bt_eol[$], bt_last[$], bt_cyc[$];
    int iss_tot = 0, acc_tot = 0;
    int done_cnt = 0, done_cyc = -1;
    bit busy_seen = 0;
    bit held = 0;
    int held_d = 0, held_f = 0;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_x.push_back(int'(mem_addr_x));
            rd_y.push_back(int'(mem_addr_y));
            rd_cyc.push_back(cyc);
            iss_tot++;
        end
        if (out_valid && out_ready) begin
            bt_d.push_back(int'(out_data));
            bt_eol.push_back(int'(out_eol));
            bt_last.push_back(int'(out_last));
            bt_cyc.push_back(cyc);
            acc_tot++;
        end
        if (busy) begin
            busy_seen = 1;
            check("occupancy_le_2", int'((iss_tot - acc_tot) <= 2), 1);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (held && out_valid) begin
            check("hold_data", int'(out_data), held_d);
            check("hold_flags", int'({out_eol, out_last}), held_f);
        end
        held   = out_valid && !out_ready;
        held_d = int'(out_data);
        held_f = int'({out_eol, out_last});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_x.delete(); rd_y.delete(); rd_cyc.delete();
        bt_d.delete(); bt_eol.delete(); bt_last.delete(); bt_cyc.delete();
        iss_tot = 0; acc_tot = 0; done_cnt = 0; done_cyc = -1; busy_seen = 0;
    endtask

    // start is high for exactly cycle t.
    task automatic launch(input int x, input int y, input int w, input int h, output int t);
        tick();
        x0 = 6'(x); y0 = 5'(y); win_w = 7'(w); win_h = 6'(h);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit toggle);
        int k;
        logic [3:0] pat;
        pat = 4'b1001;  // ready per cycle: 1,0,0,1
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            if (toggle) out_ready = pat[3 - (k % 4)];
            tick();
            k++;
        end
        out_ready = 1'b1;
        if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr_x"}, int'(mem_addr_x), 0);
        check({tag, "_addr_y"}, int'(mem_addr_y), 0);
        check({tag, "_rd_en"}, int'(mem_rd_en), 0);
        check({tag, "_wr_en"}, int'(mem_wr_enable), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_eol"}, int'(out_eol), 0);
        check({tag, "_last"}, int'(out_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // 4x2 window at the origin.
`ifdef MEM2D_RD_COLMAJOR_EN
    int exp_d[8]   = '{0, 8, 1, 9, 2, 10, 3, 11};
    int exp_eol[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int wrap_x[6]  = '{62, 62, 63, 63, 0, 0};
    int wrap_y[6]  = '{31, 0, 31, 0, 31, 0};
`else
    int exp_d[8]   = '{0, 1, 2, 3, 8, 9, 10, 11};
    int exp_eol[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int wrap_x[6]  = '{62, 63, 0, 62, 63, 0};
    int wrap_y[6]  = '{31, 31, 31, 0, 0, 0};
`endif

    task automatic check_4x2(input string tag);
        check({tag, "_beats"}, bt_d.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_data%0d", tag, i), at(bt_d, i), exp_d[i]);
            check($sformatf("%s_eol%0d", tag, i), at(bt_eol, i), exp_eol[i]);
            check($sformatf("%s_last%0d", tag, i), at(bt_last, i), (i == 7) ? 1 : 0);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int t;

        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset");

        // Basic 4x2 scan with out_ready held high.
        clear_log();
        launch(0, 0, 4, 2, t);
        wait_done("t1", 100, 1'b0);
        check_4x2("t1");
        check("t1_first_rd_cyc", at(rd_cyc, 0), t + 1);
        check("t1_first_beat_cyc", at(bt_cyc, 0), t + 2);
        check("t1_last_beat_cyc", at(bt_cyc, 7), t + 9);
        check("t1_done_cyc", done_cyc, t + 10);
        tick();
        check("t1_busy_after", int'(busy), 0);

        // Wrap in X and Y.
        clear_log();
        launch(62, 31, 3, 2, t);
        wait_done("wrap", 100, 1'b0);
        check("wrap_reads", rd_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wrap_x%0d", i), at(rd_x, i), wrap_x[i]);
            check($sformatf("wrap_y%0d", i), at(rd_y, i), wrap_y[i]);
            check($sformatf("wrap_data%0d", i), at(bt_d, i), int'(mem_val(wrap_x[i], wrap_y[i])));
        end
        check("wrap_last", at(bt_last, 5), 1);

        // Same 4x2 window under backpressure.
        clear_log();
        launch(0, 0, 4, 2, t);
        wait_done("bp", 300, 1'b1);
        check_4x2("bp");
        check("bp_reads", rd_x.size(), 8);

        // Zero-width window is ignored.
        clear_log();
        launch(3, 3, 0, 4, t);
        repeat (10) tick();
        check("w0_busy_seen", int'(busy_seen), 0);
        check("w0_reads", rd_x.size(), 0);
        check("w0_beats", bt_d.size(), 0);

        // 1x1 window; a start coinciding with done is ignored.
        clear_log();
        launch(10, 2, 1, 1, t);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("w1_busy_after_done_start", int'(busy), 0);
        repeat (4) tick();
        check("w1_reads", rd_x.size(), 1);
        check("w1_beats", bt_d.size(), 1);
        check("w1_data", at(bt_d, 0), 26);
        check("w1_eol", at(bt_eol, 0), 1);
        check("w1_last", at(bt_last, 0), 1);
        check("w1_done_cyc", done_cyc, t + 3);
        check("w1_done_cnt", done_cnt, 1);

        // Reset three cycles into a full-memory scan.
        clear_log();
        launch(0, 0, 64, 32, t);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst");
        tick();
        check("midrst_valid_next", int'(out_valid), 0);
        clear_log();
        launch(5, 7, 2, 1, t);
        wait_done("post", 100, 1'b0);
        check("post_x0", at(rd_x, 0), 5);
        check("post_y0", at(rd_y, 0), 7);
        check("post_beats", bt_d.size(), 2);
        check("post_data0", at(bt_d, 0), 61);
        check("post_data1", at(bt_d, 1), 62);
        check("post_first_beat_cyc", at(bt_cyc, 0), t + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem2d_raster_reader.md
# mem2d_raster_reader

Read-side client for the 64×32×8 two-dimensional byte memory. On a start pulse it scans a rectangular window of the memory in raster order and issues one read per element. It streams the returned bytes out on a valid/ready interface with row and frame markers. It sits between the 2-D memory and any downstream consumer, such as a display, serializer or checksum unit, and never writes the memory.

## Interface
Parameters:
- AX_W, default 6: memory X address width (64 columns).
- AY_W, default 5: memory Y address width (32 rows).
- DATA_W, default 8: element width.

Ports:
- clk, input, 1: single clock, all logic rising-edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a scan; sampled only in IDLE.
- x0, input, AX_W: window origin column.
- y0, input, AY_W: window origin row.
- win_w, input, AX_W+1: window width in elements, 1..64.
- win_h, input, AY_W+1: window height in elements, 1..32.
- mem_addr_x, output, AX_W: memory column address.
- mem_addr_y, output, AY_W: memory row address.
- mem_rd_en, output, 1: read strobe; data returns on mem_data the next cycle.
- mem_wr_enable, output, 1: tied 0.
- mem_data, input, DATA_W: read data, valid one cycle after mem_rd_en.
- out_data, output, DATA_W: streamed element.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: consumer accepts.
- out_eol, output, 1: element is the last of its row.
- out_last, output, 1: element is the last of the window.
- busy, output, 1: scan in progress.
- done, output, 1: one-cycle pulse after the final beat is accepted.

## Operation
- FSM states:
  - IDLE: start with legal win_w and win_h latches x0, y0, win_w and win_h, clears the col/row counters, then goes to SCAN.
  - SCAN: issues reads until the last element is issued, then goes to DRAIN.
  - DRAIN: waits until the buffer is empty and nothing is in flight; pulses done and goes to IDLE.
- A start with win_w==0 or win_h==0 is ignored and stays in IDLE. start in SCAN or DRAIN is ignored.
- Address generation: mem_addr_x = x0+col and mem_addr_y = y0+row, truncated to AX_W/AY_W. Windows therefore wrap modulo 64 in X and modulo 32 in Y.
- col increments per issued read. At col==win_w-1, col goes to 0 and row increments.
- Read-issue rule: issue when (fifo_count + inflight − pop) < 2.
  - pop = out_valid & out_ready.
  - inflight = mem_rd_en of the previous cycle.
  - This sustains one element per cycle when out_ready is held high.
- Returned data is pushed into a 2-entry FIFO together with eol/last flags.
  - eol and last are computed at issue time and pipelined one cycle.
- out_data, out_eol and out_last come from the FIFO head. out_valid = FIFO not empty.
- Once out_valid rises, out_data and the flags are stable until accepted.
- busy = state != IDLE.
- mem_addr_x and mem_addr_y hold their last value when mem_rd_en is low.

## Timing
- Reset values: state IDLE, all counters 0, FIFO empty. All outputs 0: mem_addr_x, mem_addr_y, mem_rd_en, out_valid, out_data, out_eol, out_last, busy, done.
- Latency:
  - start in cycle T: first mem_rd_en in T+1, first out_valid in T+2.
  - With out_ready held high, a W×H window finishes its last beat at T+1+W·H.
  - done is asserted at T+2+W·H.
- Backpressure: at most 2 elements are buffered. No element is dropped or duplicated for any out_ready pattern.
- rst asserted mid-scan: the next cycle is in IDLE with the FIFO flushed and outputs at reset values. A read still in flight is discarded.
- done and start in the same cycle: start is ignored, because state is still DRAIN.

## Configuration
- MEM2D_RD_COLMAJOR_EN defined: the scan is column-major.
  - row increments fastest; col increments when row wraps at win_h−1.
  - out_eol marks the last element of each column.
  - Wrap behaviour and latency are unchanged.
- MEM2D_RD_COLMAJOR_EN undefined: row-major scan as described above.

## Structure
- Package mem2d_pkg holds:
  - the AX_W, AY_W and DATA_W defaults;
  - the FSM state enum {IDLE, SCAN, DRAIN};
  - the FIFO entry struct {data, eol, last}.
- Sub-module mem2d_rd_skid: 2-entry synchronous FIFO.
  - Ports: push, pop, count, head.
  - Synchronous reset, shared by the future write-side streamer.

## Test plan
- x0=0, y0=0, win_w=4, win_h=2, memory preloaded with mem[x][y]=x+8y, out_ready=1:
  - out_data sequence 0,1,2,3,8,9,10,11;
  - out_eol on beats 3 and 7, out_last on beat 7;
  - done 10 cycles after start.
- x0=62, y0=31, win_w=3, win_h=2: addresses are (62,31),(63,31),(0,31),(62,0),(63,0),(0,0), exercising wrap in X and Y.
- Same 4×2 window with out_ready toggling 1,0,0,1: the stream matches the first test, each element is held stable while out_ready=0, and mem_rd_en never overflows the FIFO.
- Degenerate windows:
  - win_w=0 with start: busy stays 0 and there are no reads.
  - win_w=1, win_h=1: exactly one beat with eol=last=1.
- rst asserted 3 cycles into a 64×32 scan: all outputs return to 0 the next cycle. A new start then produces a clean first beat from (x0,y0).
- Build with MEM2D_RD_COLMAJOR_EN and repeat the first test: sequence 0,8,1,9,2,10,3,11, with eol every second beat.
